// File: rtl/logic_pkg.sv
// ---------------------------------------------------------------------------
// logic_pkg
// Shared definitions for the bitwise logic datapath.
//  - logic_op_e : 3-bit logic opcode as presented by the decoder
//  - SEL_*      : 4-bit minterm select codes. Bit index is {op2_bit, op1_bit}.
//  - op_to_sel  : opcode -> {logic_sel[3:0], illegal}
// ---------------------------------------------------------------------------
package logic_pkg;

    typedef enum logic [2:0] {
        LOP_AND  = 3'b000,
        LOP_OR   = 3'b001,
        LOP_XOR  = 3'b010,
        LOP_ANDN = 3'b011,
        LOP_ORN  = 3'b100,
        LOP_XNOR = 3'b101,
        LOP_PASS = 3'b110,
        LOP_RSVD = 3'b111
    } logic_op_e;

    localparam int TAG_W = 5;

    localparam logic [3:0] SEL_AND  = 4'b1000;
    localparam logic [3:0] SEL_OR   = 4'b1110;
    localparam logic [3:0] SEL_XOR  = 4'b0110;
    localparam logic [3:0] SEL_ANDN = 4'b0010;
    localparam logic [3:0] SEL_ORN  = 4'b1011;
    localparam logic [3:0] SEL_XNOR = 4'b1001;
    localparam logic [3:0] SEL_PASS = 4'b1100;
    // All-zero select forces every result bit to 0 for reserved opcodes.
    localparam logic [3:0] SEL_NONE = 4'b0000;

    function automatic logic [4:0] op_to_sel(input logic [2:0] op);
        logic [4:0] r;
        case (op)
            LOP_AND:  r = {SEL_AND,  1'b0};
            LOP_OR:   r = {SEL_OR,   1'b0};
            LOP_XOR:  r = {SEL_XOR,  1'b0};
            LOP_ANDN: r = {SEL_ANDN, 1'b0};
            LOP_ORN:  r = {SEL_ORN,  1'b0};
            LOP_XNOR: r = {SEL_XNOR, 1'b0};
            LOP_PASS: r = {SEL_PASS, 1'b0};
            default:  r = {SEL_NONE, 1'b1};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_issue_unit_word.sv
// ---------------------------------------------------------------------------
// logic_bit / logic_word
// Purely combinational minterm logic array.
//  logic_bit  : a, b (1-bit operands), sel[3:0] -> y = sel[{b,a}]
//  logic_word : op1, op2 (XLEN), logic_sel[3:0] shared by all slices
//               -> result (XLEN)
// ---------------------------------------------------------------------------
module logic_bit (
    input  logic       a,
    input  logic       b,
    input  logic [3:0] sel,
    output logic       y
);
    assign y = sel[{b, a}];
endmodule

module logic_word #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [3:0]      logic_sel,
    output logic [XLEN-1:0] result
);
    for (genvar i = 0; i < XLEN; i++) begin : g_slice
        logic_bit u_bit (
            .a   (op1[i]),
            .b   (op2[i]),
            .sel (logic_sel),
            .y   (result[i])
        );
    end
endmodule

// File: rtl/logic_issue_unit.sv
// ---------------------------------------------------------------------------
// logic_issue_unit
// Two-stage issue/execute pipe for RV32 bitwise logic operations.
// Stage 1 decodes the opcode to a minterm select and captures operands;
// stage 2 evaluates the logic array and holds the result for the consumer.
// Ports:
//  clk, rst_n                 clock, async active-low reset
//  in_valid/in_ready          request handshake
//  in_op, in_op1, in_op2      opcode and operands
//  in_tag                     destination tag, passed through
//  flush                      drop everything in flight (and this cycle's input)
//  out_valid/out_ready        result handshake
//  out_result, out_tag        result and its tag
//  out_illegal                reserved opcode seen; out_result is 0
// ---------------------------------------------------------------------------
module logic_issue_unit
    import logic_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_op1,
    input  logic [XLEN-1:0]  in_op2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    logic             vld_p1;
    logic             vld_p2;
    logic             adv_p2;
    logic             accept;

    logic [3:0]       dec_sel;
    logic             dec_ill;

    logic [XLEN-1:0]  op1_p1;
    logic [XLEN-1:0]  op2_p1;
    logic [3:0]       sel_p1;
    logic             ill_p1;
    logic [TAG_W-1:0] tag_p1;

    logic [XLEN-1:0]  word_res;

    logic [XLEN-1:0]  res_p2;
    logic             ill_p2;
    logic [TAG_W-1:0] tag_p2;

    assign {dec_sel, dec_ill} = op_to_sel(in_op);

    // Output register frees up when empty or being consumed; stage 1 may
    // refill in the same cycle it hands off, so a full pipe streams.
    assign adv_p2   = !vld_p2 || out_ready;
    assign in_ready = !vld_p1 || adv_p2;
    assign accept   = in_valid && in_ready && !flush;

    // Control: only the valid bits are reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (in_ready) begin
                vld_p1 <= in_valid;
            end
            if (adv_p2) begin
                vld_p2 <= vld_p1;
            end
        end
    end

    // ---- stage 1: decode / operand capture ----
    always_ff @(posedge clk) begin
        if (accept) begin
            op1_p1 <= in_op1;
            op2_p1 <= in_op2;
            sel_p1 <= dec_sel;
            ill_p1 <= dec_ill;
            tag_p1 <= in_tag;
        end
    end

    logic_word #(.XLEN(XLEN)) u_word (
        .op1       (op1_p1),
        .op2       (op2_p1),
        .logic_sel (sel_p1),
        .result    (word_res)
    );

    // ---- stage 2: execute / output register ----
    always_ff @(posedge clk) begin
        if (adv_p2 && vld_p1) begin
            res_p2 <= word_res;
            ill_p2 <= ill_p1;
            tag_p2 <= tag_p1;
        end
    end

    // Data registers are unreset, so outputs are masked to 0 when idle.
    assign out_valid   = vld_p2;
    assign out_result  = vld_p2 ? res_p2 : '0;
    assign out_tag     = vld_p2 ? tag_p2 : '0;
    assign out_illegal = vld_p2 && ill_p2;

endmodule

// File: tb/tb_logic_issue_unit.sv
module tb_logic_issue_unit;
    import logic_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = 3'b000;
    logic [31:0] in_op1 = '0;
    logic [31:0] in_op2 = '0;
    logic [4:0]  in_tag = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        out_illegal;

    logic_issue_unit #(.XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_op1      (in_op1),
        .in_op2      (in_op2),
        .in_tag      (in_tag),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_tag     (out_tag),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        logic        ill;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    localparam logic [31:0] OP1 = 32'hF0F0_00FF;
    localparam logic [31:0] OP2 = 32'hFF00_0F0F;

    logic [31:0] exp_tab [8];
    logic        ill_tab [8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Present one request and hold it until accepted; push its expectation.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [31:0] er, input logic eil,
                         input bit lat);
        bit done;
        done = 0;
        in_valid = 1'b1;
        in_op = op;
        in_op1 = a;
        in_op2 = b;
        in_tag = tag;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back('{er, tag, eil, cyc, lat});
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout tag %0d: in_ready stayed 0 for 20 cycles, required 1", tag);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every consumed output must match the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got result %h tag %0d, required no output",
                         out_result, out_tag);
            end else begin
                e = sb.pop_front();
                chk($sformatf("result tag%0d", e.tag), out_result, e.res);
                chk($sformatf("tag tag%0d", e.tag), {27'd0, out_tag}, {27'd0, e.tag});
                chk($sformatf("illegal tag%0d", e.tag), {31'd0, out_illegal}, {31'd0, e.ill});
                if (e.lat) chk($sformatf("latency tag%0d", e.tag), cyc - e.cyc, 32'd2);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int nr, nv, first, last;
        exp_tab[0] = 32'hF000_000F; ill_tab[0] = 1'b0;  // AND
        exp_tab[1] = 32'hFFF0_0FFF; ill_tab[1] = 1'b0;  // OR
        exp_tab[2] = 32'h0FF0_0FF0; ill_tab[2] = 1'b0;  // XOR
        exp_tab[3] = 32'h00F0_00F0; ill_tab[3] = 1'b0;  // ANDN
        exp_tab[4] = 32'hF0FF_F0FF; ill_tab[4] = 1'b0;  // ORN
        exp_tab[5] = 32'hF00F_F00F; ill_tab[5] = 1'b0;  // XNOR
        exp_tab[6] = 32'hFF00_0F0F; ill_tab[6] = 1'b0;  // PASS
        exp_tab[7] = 32'h0000_0000; ill_tab[7] = 1'b1;  // reserved

        // Reset state
        #2;
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset out_result", out_result, 32'd0);
        chk("reset out_tag", {27'd0, out_tag}, 32'd0);
        chk("reset out_illegal", {31'd0, out_illegal}, 32'd0);
        #10 rst_n = 1'b1;
        idle(1);

        // Single requests
        for (int i = 0; i < 7; i++) begin
            issue(i[2:0], OP1, OP2, 5'(i + 1), exp_tab[i], 1'b0, 1);
            idle(3);
        end

        // Reserved opcode
        issue(3'b111, 32'h1234_5678, 32'hDEAD_BEEF, 5'd21, 32'd0, 1'b1, 1);
        idle(3);

        // Back-to-back stream of 8
        nr = 0; nv = 0; first = -1; last = -1;
        fork
            for (int i = 0; i < 8; i++) issue(i[2:0], OP1, OP2, 5'(8 + i), exp_tab[i], ill_tab[i], 1);
            repeat (8) begin
                @(negedge clk);
                if (!in_ready) nr++;
            end
            repeat (12) begin
                @(negedge clk);
                if (out_valid) begin
                    nv++;
                    if (first < 0) first = cyc;
                    last = cyc;
                end
            end
        join
        chk("stream in_ready_low_cycles", nr, 32'd0);
        chk("stream out_valid_count", nv, 32'd8);
        chk("stream out_valid_span", last - first + 1, 32'd8);
        idle(3);

        // Stall with 3 requests
        out_ready = 1'b0;
        issue(3'd0, OP1, OP2, 5'd16, exp_tab[0], 1'b0, 0);
        issue(3'd1, OP1, OP2, 5'd17, exp_tab[1], 1'b0, 0);
        fork
            issue(3'd2, OP1, OP2, 5'd18, exp_tab[2], 1'b0, 1);
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("stall in_ready", {31'd0, in_ready}, 32'd0);
                    chk("stall out_valid", {31'd0, out_valid}, 32'd1);
                    chk("stall out_result", out_result, exp_tab[0]);
                    chk("stall out_tag", {27'd0, out_tag}, 32'd16);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        idle(4);

        // Flush with 2 in flight plus a simultaneous request
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 3'd0; in_op1 = OP1; in_op2 = OP2; in_tag = 5'd24;
        idle(1);
        in_op = 3'd1; in_tag = 5'd25;
        idle(1);
        in_op = 3'd2; in_tag = 5'd26; flush = 1'b1;
        idle(1);
        in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush out_valid_next", {31'd0, out_valid}, 32'd0);
        // Flush on an empty pipe drops a request even though in_ready is 1
        @(posedge clk);
        #1 out_ready = 1'b1;
        in_valid = 1'b1; in_op = 3'd3; in_tag = 5'd27; flush = 1'b1;
        @(negedge clk);
        chk("flush_empty in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b0;
        nv = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        chk("flush no_output", nv, 32'd0);
        @(posedge clk);
        #1;
        issue(3'd4, OP1, OP2, 5'd28, exp_tab[4], 1'b0, 1);
        idle(4);

        // Asynchronous reset with a full pipe
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 3'd5; in_tag = 5'd29;
        idle(1);
        in_op = 3'd6; in_tag = 5'd30;
        idle(1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("prereset out_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_reset in_ready", {31'd0, in_ready}, 32'd1);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        issue(3'd6, 32'h0BAD_F00D, 32'hCAFE_1234, 5'd31, 32'hCAFE_1234, 1'b0, 1);
        idle(5);

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic_issue_unit.md
Name: logic_issue_unit

Overview:
- Producer/driver side of the bitwise logic datapath in the integer execution unit.
- Accepts decoded RV32 logic operations (AND/OR/XOR/ANDN/ORN/XNOR/PASS) with a valid/ready handshake and translates each opcode into the 4-bit per-bit minterm select.
- Drives a 32-slice minterm logic array and returns registered results through a 2-stage pipeline with backpressure and flush.

Parameters:
- XLEN, 32, operand and result width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request this cycle.
- in_op  input  3  logic opcode (encoding in package).
- in_op1  input  XLEN  operand 1 (rs1).
- in_op2  input  XLEN  operand 2 (rs2 or immediate).
- in_tag  input  5  destination register tag, passed through unchanged.
- flush  input  1  kill all in-flight requests.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_result  output  XLEN  logic result.
- out_tag  output  5  tag of the result.
- out_illegal  output  1  opcode was reserved; out_result is 0.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low.
- Reset values: all outputs 0, except in_ready = 1 (combinational from empty state). Both stage valid bits are cleared.
- Opcode decode to logic_sel[3:0]. Bit 0 is the minterm op1=0,op2=0; bit 1 is op1=1,op2=0; bit 2 is op1=0,op2=1; bit 3 is op1=1,op2=1.
  - AND=000 -> 1000
  - OR=001 -> 1110
  - XOR=010 -> 0110
  - ANDN=011 (op1 & ~op2) -> 0010
  - ORN=100 (op1 | ~op2) -> 1011
  - XNOR=101 -> 1001
  - PASS=110 (result = op2) -> 1100
  - 111 is reserved: logic_sel = 0000, illegal = 1.
- Per-bit result: result bit i equals logic_sel[{op2[i],op1[i]}]. The select is shared by all bits.
- Stage 1 (decode): on in_valid && in_ready, register op1, op2, logic_sel, illegal and tag; s1_valid <= 1.
- Stage 2 (execute): evaluate the logic array on the stage-1 registers and register result, tag and illegal into the output register; s2_valid drives out_valid.
- Latency: out_valid asserts exactly 2 cycles after the accepting edge when out_ready is held high. Throughput is 1 per cycle.
- Backpressure:
  - s2 advances when !s2_valid || out_ready.
  - s1 advances into s2 under the same condition.
  - in_ready = !s1_valid || s2_advance (combinational from registers and out_ready).
- Stalled outputs: while out_valid && !out_ready, out_result, out_tag and out_illegal hold stable.
- Simultaneous in and out handshake in a full pipe: both complete. There is no bubble and no loss.
- flush:
  - Synchronous; clears s1_valid and s2_valid at the next edge.
  - A request presented in the same cycle as flush is dropped, even if in_ready was 1.
  - out_valid is 0 in the cycle after flush.
- Reset mid-operation: all valids are cleared immediately. No partial result escapes.
- Data registers need no reset; valid bits do.

Decomposition:
- Package logic_pkg:
  - typedef enum logic [2:0] logic_op_e with values LOP_AND..LOP_PASS and LOP_RSVD.
  - localparam constants for the 4-bit select codes.
  - function automatic op_to_sel() returning {sel, illegal}.
- Sub-module logic_word #(XLEN): a purely combinational array of XLEN instances of the existing 1-bit logic block, sharing one logic_sel.

Test Plan:
1. Single requests, out_ready=1, op1=0xF0F0_00FF, op2=0xFF00_0F0F; each result appears 2 cycles after acceptance, tag echoed, out_illegal=0.
   - AND -> 0xF000_000F
   - OR -> 0xFFF0_0FFF
   - XOR -> 0x0FF0_0FF0
   - ANDN -> 0x00F0_00F0
   - ORN -> 0xF0FF_F0FF
   - XNOR -> 0xF00F_F00F
   - PASS -> 0xFF00_0F0F
2. Opcode 111 with any operands -> out_illegal=1, out_result=0x0000_0000, tag preserved.
3. Back-to-back stream of 8 ops with out_ready=1 -> 8 consecutive out_valid cycles, results in order, in_ready constantly 1.
4. Stall: fill with 3 requests, then hold out_ready=0 for 5 cycles.
   - in_ready drops after 2 are buffered.
   - out_result is stable throughout.
   - On release, all results drain in order with no loss or duplication.
5. Flush with 2 in flight plus a simultaneous new request -> out_valid=0 next cycle and no result ever appears for those 3. A request issued after the flush completes normally.
6. Assert rst_n=0 asynchronously between edges with a full pipe -> out_valid=0 and in_ready=1 immediately. After release, the first new request returns in 2 cycles.
